inst_encoder: RTL and testbench

Pipelined RISC-V instruction encoder: the inverse of the core's immediate extractor. It takes decoded fields (opcode, registers, funct bits, a 32-bit signed/aligned immediate and a format select) and packs them into a 32-bit instruction word. Each accepted word is tagged with a sequential instruction-memory address. It sits in the program-loader/test-generator path ahead of the instruction-memory write port and uses valid/ready handshakes on both sides.

---
 rtl/inst_pkg.sv | 38 +++
 rtl/inst_encoder_imm_packer.sv | 57 +++++
 rtl/inst_encoder.sv | 119 +++++++++++
 tb/tb_inst_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared definitions for the RISC-V instruction encoder.
// Covers format codes, error codes, common opcodes and the decoded-field bundle.
package inst_pkg;

   typedef enum logic [2:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_J = 3'b011,
      FMT_U = 3'b100,
      FMT_R = 3'b101
   } fmt_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'b00,
      ERR_RANGE = 2'b01,
      ERR_ALIGN = 2'b10,
      ERR_FMT   = 2'b11
   } err_e;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_LUI    = 7'h37;

   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [2:0]  funct3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  funct7;
      logic [31:0] imm;
   } fields_t;

endpackage

// File: rtl/inst_encoder_imm_packer.sv
// Combinational format mux: scatters the immediate into its instruction slots
// and flags out-of-range, misaligned or unknown-format inputs.
module imm_packer
   import inst_pkg::*;
(
   input  fields_t     f,
   output logic [31:0] inst,
   output err_e        err
);

   logic is_ok;
   logic b_ok;
   logic j_ok;
   logic u_ok;

   // Sign-extension test: the discarded upper bits must all copy the sign bit.
   assign is_ok = (&f.imm[31:11]) | ~(|f.imm[31:11]);
   assign b_ok  = (&f.imm[31:12]) | ~(|f.imm[31:12]);
   assign j_ok  = (&f.imm[31:20]) | ~(|f.imm[31:20]);
   assign u_ok  = ~(|f.imm[11:0]);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      inst = '0;
      err  = ERR_NONE;
      case (f.fmt)
         FMT_I: begin
            inst = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            if (!is_ok) err = ERR_RANGE;
         end
         FMT_S: begin
            inst = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            if (!is_ok) err = ERR_RANGE;
         end
         FMT_B: begin
            inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                    f.imm[4:1], f.imm[11], f.opcode};
            if (f.imm[0])   err = ERR_ALIGN;
            else if (!b_ok) err = ERR_RANGE;
         end
         FMT_J: begin
            inst = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            if (f.imm[0])   err = ERR_ALIGN;
            else if (!j_ok) err = ERR_RANGE;
         end
         FMT_U: begin
            inst = {f.imm[31:12], f.rd, f.opcode};
            if (!u_ok) err = ERR_RANGE;
         end
         FMT_R: begin
            inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
         end
         default: err = ERR_FMT;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage instruction encoder: stage 1 holds decoded fields and their packed
// word, stage 2 is the output register; rejected words only bump the error state.
module inst_encoder
   import inst_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [2:0]  funct3,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [31:0] out_addr,
   output logic [7:0]  err_cnt,
   output logic [1:0]  err_code
);

   fields_t     s1_fields_q, s1_fields_d;
   logic        s1_valid_q, s1_valid_d;
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] s2_inst_q, s2_inst_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   err_e        err_code_q, err_code_d;

   logic [31:0] s1_inst;
   err_e        s1_err;
   logic        in_fire, out_fire, s1_reject, s1_to_s2;

   imm_packer u_packer (
      .f    (s1_fields_q),
      .inst (s1_inst),
      .err  (s1_err)
   );

   assign in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = s2_valid_q && out_ready;
   assign s1_reject = s1_valid_q && (s1_err != ERR_NONE);
   assign s1_to_s2  = s1_valid_q && (s1_err == ERR_NONE) && (!s2_valid_q || out_ready);

   always_comb begin
      s1_fields_d = s1_fields_q;
      s1_valid_d  = s1_valid_q;
      s2_valid_d  = s2_valid_q;
      s2_inst_d   = s2_inst_q;
      addr_d      = addr_q;
      err_cnt_d   = err_cnt_q;
      err_code_d  = err_code_q;
      if (clear) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
         s2_inst_d  = '0;
         addr_d     = BASE_ADDR;
         err_cnt_d  = '0;
         err_code_d = ERR_NONE;
      end else begin
         if (out_fire) begin
            s2_valid_d = 1'b0;
            addr_d     = addr_q + 32'd4;
         end
         if (s1_to_s2) begin
            s2_valid_d = 1'b1;
            s2_inst_d  = s1_inst;
         end
         if (s1_reject) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            err_code_d = s1_err;
         end
         if (s1_to_s2 || s1_reject) s1_valid_d = 1'b0;
         if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_fields_d = '{fmt: fmt, opcode: opcode, rd: rd, funct3: funct3,
                            rs1: rs1, rs2: rs2, funct7: funct7, imm: imm};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_inst_q  <= '0;
         addr_q     <= BASE_ADDR;
         err_cnt_q  <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_inst_q  <= s2_inst_d;
         addr_q     <= addr_d;
         err_cnt_q  <= err_cnt_d;
         err_code_q <= err_code_d;
      end
   end

   // NOTE: stage-1 payload is left unreset; s1_valid_q qualifies every use of it.
   always_ff @(posedge clk) begin
      s1_fields_q <= s1_fields_d;
   end

   assign out_valid = s2_valid_q;
   assign out_inst  = s2_inst_q;
   assign out_addr  = addr_q;
   assign err_cnt   = err_cnt_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: packing per format, error handling,
// backpressure, clear, error-counter saturation and address wrap.
module tb_inst_encoder;
   import inst_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;

   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]  fmt;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic [31:0] out_inst, out_addr;
   logic [7:0]  err_cnt;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_err    = 0;
   int accepted;

   always #5 clk = ~clk;

   inst_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_addr(out_addr),
      .err_cnt(err_cnt), .err_code(err_code)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b,
                         input logic [6:0] f7, input logic [31:0] im);
      in_valid = 1'b1;
      fmt = f; opcode = op; rd = d; funct3 = f3;
      rs1 = a; rs2 = b; funct7 = f7; imm = im;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   // Backpressure stream words.
   task automatic set_w(input int k);
      case (k)
         1: set_in(FMT_R, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'h0);
         2: set_in(FMT_U, OP_LUI, 5'd10, 3'd0, 5'd0, 5'd0, 7'h0, 32'hABCD_E000);
         3: set_in(FMT_I, OP_IMM, 5'd3, 3'd0, 5'd3, 5'd0, 7'h0, 32'hFFFF_F800);
         default: set_in(FMT_B, OP_BRANCH, 5'd0, 3'd1, 5'd1, 5'd2, 7'h0, 32'd4094);
      endcase
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
      idle();
      set_in(FMT_I, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'h0);
      idle();
      cyc(); cyc();
      check("rst out_valid", {31'b0, out_valid}, 32'd0);
      check("rst out_inst", out_inst, 32'h0);
      check("rst out_addr", out_addr, BASE);
      check("rst err_cnt", {24'b0, err_cnt}, 32'd0);
      check("rst err_code", {30'b0, err_code}, 32'd0);
      rst_n = 1'b1;
      cyc();
      check("rst in_ready", {31'b0, in_ready}, 32'd1);

      // Single I-type word.
      set_in(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5);
      #1 check("i in_ready", {31'b0, in_ready}, 32'd1);
      cyc();
      idle();
      #1 check("i no early out", {31'b0, out_valid}, 32'd0);
      cyc();
      check("i out_valid", {31'b0, out_valid}, 32'd1);
      check("i out_inst", out_inst, 32'h0050_0093);
      check("i out_addr", out_addr, BASE);
      cyc();
      check("i drained", {31'b0, out_valid}, 32'd0);

      // Back-to-back S, B, J, U; last one lands on the wrapped address.
      set_in(FMT_S, OP_STORE, 5'd0, 3'd2, 5'd1, 5'd2, 7'h0, 32'd8);
      cyc();
      set_in(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'hFFFF_FFFC);
      #1 check("b2b bubble0", {31'b0, out_valid}, 32'd0);
      cyc();
      set_in(FMT_J, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'h800);
      #1 check("s inst", out_inst, 32'h0020_A423);
      check("s addr", out_addr, BASE + 32'd4);
      check("s valid", {31'b0, out_valid}, 32'd1);
      cyc();
      set_in(FMT_U, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'h0, 32'h1234_5000);
      #1 check("b inst", out_inst, 32'hFE00_0EE3);
      check("b addr", out_addr, BASE + 32'd8);
      check("b valid", {31'b0, out_valid}, 32'd1);
      cyc();
      idle();
      #1 check("j inst", out_inst, 32'h0010_00EF);
      check("j addr", out_addr, 32'hFFFF_FFFC);
      check("j valid", {31'b0, out_valid}, 32'd1);
      cyc();
      check("u inst", out_inst, 32'h1234_52B7);
      check("u addr wrap", out_addr, 32'h0000_0000);
      check("u valid", {31'b0, out_valid}, 32'd1);
      cyc();
      check("b2b drained", {31'b0, out_valid}, 32'd0);
      check("b2b next addr", out_addr, 32'h4);

      // Rejected inputs.
      set_in(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd2048);
      cyc(); idle(); cyc();
      check("range no out", {31'b0, out_valid}, 32'd0);
      check("range cnt", {24'b0, err_cnt}, 32'd1);
      check("range code", {30'b0, err_code}, 32'd1);
      set_in(FMT_B, OP_BRANCH, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5);
      cyc(); idle(); cyc();
      check("align no out", {31'b0, out_valid}, 32'd0);
      check("align cnt", {24'b0, err_cnt}, 32'd2);
      check("align code", {30'b0, err_code}, 32'd2);
      set_in(3'b111, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'd0);
      cyc(); idle(); cyc();
      check("fmt no out", {31'b0, out_valid}, 32'd0);
      check("fmt cnt", {24'b0, err_cnt}, 32'd3);
      check("fmt code", {30'b0, err_code}, 32'd3);
      set_in(FMT_I, OP_IMM, 5'd2, 3'd0, 5'd1, 5'd0, 7'h0, 32'hFFFF_FFFF);
      cyc(); idle(); cyc();
      check("post-err valid", {31'b0, out_valid}, 32'd1);
      check("post-err inst", out_inst, 32'hFFF0_8113);
      check("post-err addr", out_addr, 32'h4);
      check("post-err code kept", {30'b0, err_code}, 32'd3);
      cyc();

      // Backpressure: out_ready low for 5 cycles while streaming 4 words.
      out_ready = 1'b0;
      set_w(1);
      #1 check("bp ready0", {31'b0, in_ready}, 32'd1);
      cyc();
      set_w(2);
      #1 check("bp ready1", {31'b0, in_ready}, 32'd1);
      cyc();
      set_w(3);
      #1 check("bp ready drop", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("bp stall ready", {31'b0, in_ready}, 32'd0);
         check("bp stall valid", {31'b0, out_valid}, 32'd1);
         check("bp stall inst", out_inst, 32'h4031_00B3);
         check("bp stall addr", out_addr, 32'h8);
      end
      out_ready = 1'b1;
      #1 check("bp ready comb", {31'b0, in_ready}, 32'd1);
      cyc();
      set_w(4);
      #1 check("bp w2 inst", out_inst, 32'hABCD_E537);
      check("bp w2 addr", out_addr, 32'hC);
      cyc();
      idle();
      #1 check("bp w3 inst", out_inst, 32'h8001_8193);
      check("bp w3 addr", out_addr, 32'h10);
      cyc();
      check("bp w4 inst", out_inst, 32'h7E20_9FE3);
      check("bp w4 addr", out_addr, 32'h14);
      check("bp w4 valid", {31'b0, out_valid}, 32'd1);
      cyc();
      check("bp drained", {31'b0, out_valid}, 32'd0);
      check("bp end addr", out_addr, 32'h18);

      // clear with both stages full and handshakes pending.
      out_ready = 1'b0;
      set_w(1);
      cyc(); cyc();
      check("clr full", {31'b0, in_ready}, 32'd0);
      clear = 1'b1; out_ready = 1'b1;
      cyc();
      clear = 1'b0; idle();
      #1 check("clr valid", {31'b0, out_valid}, 32'd0);
      check("clr addr", out_addr, BASE);
      check("clr cnt", {24'b0, err_cnt}, 32'd0);
      check("clr code", {30'b0, err_code}, 32'd0);
      check("clr ready", {31'b0, in_ready}, 32'd1);
      cyc(); cyc();
      check("clr input dropped", {31'b0, out_valid}, 32'd0);

      // Error counter saturation.
      accepted = 0;
      set_in(3'b110, OP_IMM, 5'd0, 3'd0, 5'd0, 5'd0, 7'h0, 32'd0);
      for (int i = 0; i < 300; i++) begin
         if (in_ready) accepted++;
         cyc();
      end
      idle(); cyc(); cyc();
      check("sat accepted", accepted, 32'd300);
      check("sat cnt", {24'b0, err_cnt}, 32'd255);
      check("sat code", {30'b0, err_code}, 32'd3);
      check("sat no out", {31'b0, out_valid}, 32'd0);
      set_in(FMT_I, OP_IMM, 5'd1, 3'd0, 5'd0, 5'd0, 7'h0, 32'd5);
      cyc(); idle(); cyc();
      check("sat next addr", out_addr, BASE);
      check("sat next inst", out_inst, 32'h0050_0093);
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
